// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns single-word user read/write pulses into AXI4-Lite transactions.
// Optional response watchdog enabled by defining AXIM_TIMEOUT_EN.
module axi4_lite_master #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_ARESETN,
  input  logic                          user_wr_start,
  input  logic [AXI_ADDR_WIDTH-1:0]     user_wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     user_wr_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   user_wr_strb,
  output logic                          user_wr_idle,
  output logic [1:0]                    user_wr_resp,
  input  logic                          user_rd_start,
  input  logic [AXI_ADDR_WIDTH-1:0]     user_rd_addr,
  output logic                          user_rd_idle,
  output logic [AXI_DATA_WIDTH-1:0]     user_rd_data,
  output logic [1:0]                    user_rd_resp,
  output logic                          user_wr_timeout,
  output logic                          user_rd_timeout,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                          M_AXI_AWVALID,
  output logic [2:0]                    M_AXI_AWPROT,
  input  logic                          M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  output logic [2:0]                    M_AXI_ARPROT,
  input  logic                          M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {WR_IDLE, WR_ISSUE, WR_WAIT_B} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_WAIT_R} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                      aw_done, aw_done_next;
  logic                      w_done, w_done_next;
  logic                      wr_accept, wr_complete;
  logic                      rd_accept, rd_complete;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]         w_strb_q;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;

  assign M_AXI_AWADDR = aw_addr_q;
  assign M_AXI_WDATA  = w_data_q;
  assign M_AXI_WSTRB  = w_strb_q;
  assign M_AXI_ARADDR = ar_addr_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      wr_state <= WR_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      aw_done  <= aw_done_next;
      w_done   <= w_done_next;
      rd_state <= rd_next;
    end
  end

  // AW and W complete independently; B is only honoured once both have gone out.
  always_comb begin
    wr_next       = wr_state;
    aw_done_next  = aw_done;
    w_done_next   = w_done;
    wr_accept     = 1'b0;
    wr_complete   = 1'b0;
    user_wr_idle  = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        user_wr_idle = 1'b1;
        aw_done_next = 1'b0;
        w_done_next  = 1'b0;
        if (user_wr_start) begin
          wr_accept = 1'b1;
          wr_next   = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
        M_AXI_BREADY  = 1'b1;
        if (!aw_done && M_AXI_AWREADY) aw_done_next = 1'b1;
        if (!w_done && M_AXI_WREADY)   w_done_next  = 1'b1;
        if (aw_done && w_done && M_AXI_BVALID) begin
          wr_complete = 1'b1;
          wr_next     = WR_IDLE;
        end else if (aw_done_next && w_done_next) begin
          wr_next = WR_WAIT_B;
        end
      end
      WR_WAIT_B: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          wr_complete = 1'b1;
          wr_next     = WR_IDLE;
        end
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next       = rd_state;
    rd_accept     = 1'b0;
    rd_complete   = 1'b0;
    user_rd_idle  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        user_rd_idle = 1'b1;
        if (user_rd_start) begin
          rd_accept = 1'b1;
          rd_next   = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        M_AXI_ARVALID = 1'b1;
        M_AXI_RREADY  = 1'b1;
        if (M_AXI_ARREADY) rd_next = RD_WAIT_R;
      end
      RD_WAIT_R: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          rd_complete = 1'b1;
          rd_next     = RD_IDLE;
        end
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // Payloads are captured on the start pulse so VALID payload stays stable until handshake.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      ar_addr_q    <= '0;
      user_wr_resp <= 2'b00;
      user_rd_data <= '0;
      user_rd_resp <= 2'b00;
    end else begin
      if (wr_accept) begin
        aw_addr_q <= user_wr_addr;
        w_data_q  <= user_wr_data;
        w_strb_q  <= user_wr_strb;
      end
      if (wr_complete) user_wr_resp <= M_AXI_BRESP;
      if (rd_accept) ar_addr_q <= user_rd_addr;
      if (rd_complete) begin
        user_rd_data <= M_AXI_RDATA;
        user_rd_resp <= M_AXI_RRESP;
      end
    end
  end

`ifdef AXIM_TIMEOUT_EN
  localparam int                TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] wr_to_cnt;
  logic [TO_W-1:0] rd_to_cnt;

  // Counters saturate at the limit; the flag is sticky until the next accepted start.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      wr_to_cnt       <= '0;
      user_wr_timeout <= 1'b0;
    end else if (wr_accept) begin
      wr_to_cnt       <= '0;
      user_wr_timeout <= 1'b0;
    end else if (wr_state != WR_IDLE && wr_to_cnt != TO_LIMIT) begin
      wr_to_cnt <= wr_to_cnt + 1'b1;
      if (wr_to_cnt == TO_LIMIT - 1'b1) user_wr_timeout <= 1'b1;
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      rd_to_cnt       <= '0;
      user_rd_timeout <= 1'b0;
    end else if (rd_accept) begin
      rd_to_cnt       <= '0;
      user_rd_timeout <= 1'b0;
    end else if (rd_state != RD_IDLE && rd_to_cnt != TO_LIMIT) begin
      rd_to_cnt <= rd_to_cnt + 1'b1;
      if (rd_to_cnt == TO_LIMIT - 1'b1) user_rd_timeout <= 1'b1;
    end
  end
`else
  assign user_wr_timeout = 1'b0;
  assign user_rd_timeout = 1'b0;
`endif

endmodule
